block_transfer_unit: RTL

//  Multi-register load/store sequencer (LDM/STM) and master side of the data memory port. Sits between decode/register file and Data_Memory.

---
 rtl/block_transfer_unit_if.sv | 11 +
 rtl/block_transfer_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_unit_if.sv
// Data memory port: the transfer unit drives address, write data and write
// enable, and the memory returns read data combinationally from the address.
interface block_transfer_unit_if;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport master (output mem_A, output mem_WD, output mem_WE, input mem_RD);
    modport slave  (input mem_A, input mem_WD, input mem_WE, output mem_RD);
endinterface

// File: rtl/block_transfer_unit.sv
// LDM/STM sequencer: moves one register per cycle between the register file
// and data memory in ascending order, then writes back the updated base.
module block_transfer_unit #(
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic                  wb_en,
    input  logic [3:0]            base_reg,
    input  logic [31:0]           base_val,
    input  logic [15:0]           reg_list,
    output logic [3:0]            rf_raddr,
    input  logic [31:0]           rf_rdata,
    output logic                  rf_we,
    output logic [3:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    block_transfer_unit_if.master mem,
    output logic                  busy,
    output logic                  done
);
    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic [1:0]  mode_q, mode_d;
    logic        wb_en_q, wb_en_d;
    logic [3:0]  base_reg_q, base_reg_d;
    logic [31:0] base_val_q, base_val_d;
    logic [15:0] list_q, list_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] addr_q, addr_d;

    logic [4:0]  n_cnt;
    logic [3:0]  cur_reg;
    logic        last_xfer;
    logic [31:0] n_step;
    logic [31:0] start_addr;
    logic [31:0] wb_val;
    logic        base_in_list;
    logic [31:0] mem_wd;
    logic        mem_we;

    // Word count over the latched list; current register is the lowest bit still pending.
    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < 16; i++) n_cnt = n_cnt + {4'b0, list_q[i]};
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) if (rem_q[i]) cur_reg = 4'(i);
    end

    assign last_xfer    = (rem_q & (rem_q - 16'd1)) == 16'd0;
    assign n_step       = 32'(n_cnt) * STEP;
    assign base_in_list = list_q[base_reg_q];
    assign wb_val       = mode_q[0] ? base_val_q + n_step : base_val_q - n_step;

    // mode = {P,U}: decrementing modes start below the base so the lowest register lands lowest.
    always_comb begin
        case (mode_q)
            2'b01:   start_addr = base_val_q;
            2'b11:   start_addr = base_val_q + STEP;
            2'b00:   start_addr = base_val_q - n_step + STEP;
            default: start_addr = base_val_q - n_step;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            mode_q     <= '0;
            wb_en_q    <= 1'b0;
            base_reg_q <= '0;
            base_val_q <= '0;
            list_q     <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            mode_q     <= mode_d;
            wb_en_q    <= wb_en_d;
            base_reg_q <= base_reg_d;
            base_val_q <= base_val_d;
            list_q     <= list_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: state_d = (n_cnt == 5'd0) ? S_DONE : S_XFER;
            S_XFER:  if (last_xfer) state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_d     = load_q;
        mode_d     = mode_q;
        wb_en_d    = wb_en_q;
        base_reg_d = base_reg_q;
        base_val_d = base_val_q;
        list_d     = list_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d     = load;
                    mode_d     = mode;
                    wb_en_d    = wb_en;
                    base_reg_d = base_reg;
                    base_val_d = base_val;
                    list_d     = reg_list;
                    rem_d      = reg_list;
                end
            end
            S_SETUP: if (n_cnt != 5'd0) addr_d = start_addr;
            S_XFER: begin
                rem_d = rem_q & (rem_q - 16'd1);
                // Address stays on the last word so mem_A holds it after the burst.
                if (!last_xfer) addr_d = addr_q + STEP;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_raddr = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_SETUP: busy = 1'b1;
            S_XFER: begin
                busy = 1'b1;
                if (load_q) begin
                    rf_we    = 1'b1;
                    rf_waddr = cur_reg;
                    rf_wdata = mem.mem_RD;
                end else begin
                    rf_raddr = cur_reg;
                    mem_wd   = rf_rdata;
                    mem_we   = 1'b1;
                end
            end
            S_WB: begin
                busy = 1'b1;
                // A loaded base register keeps the value read from memory.
                if (wb_en_q && !(load_q && base_in_list)) begin
                    rf_we    = 1'b1;
                    rf_waddr = base_reg_q;
                    rf_wdata = wb_val;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_A  = addr_q;
    assign mem.mem_WD = mem_wd;
    assign mem.mem_WE = mem_we;

endmodule
